// File: rtl/carry_select_result_sink_if.sv
// -----------------------------------------------------------------------------
// carry_select_result_sink_if
//
// Purpose:
//   Bundles the two handshakes around the carry-select result sink into one
//   interface: the guarded result word coming from the carry-select adder
//   slices, and the valid/ready stream of resolved sum/carry pairs leaving it.
//
// Signals:
//   guard      producer -> sink   result word valid
//   value      producer -> sink   packed word {cout1, cout0, sum0, sum1}
//   first      producer -> sink   qualifies guard; beat starts a new chain
//   ready      sink -> producer   sink can accept this cycle
//   out_valid  sink -> consumer   FIFO head valid
//   out_ready  consumer -> sink   consumer takes the head
//   out_sum    sink -> consumer   resolved sum at the head
//   out_carry  sink -> consumer   resolved carry-out at the head
//
// Modports:
//   master  the side driving results in and taking resolved pairs out
//   slave   the sink itself
// -----------------------------------------------------------------------------
interface carry_select_result_sink_if #(
    parameter int W = 4
);
    logic             guard;
    logic [2*W+1:0]   value;
    logic             first;
    logic             ready;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic             out_carry;

    modport master (
        output guard,
        output value,
        output first,
        output out_ready,
        input  ready,
        input  out_valid,
        input  out_sum,
        input  out_carry
    );

    modport slave (
        input  guard,
        input  value,
        input  first,
        input  out_ready,
        output ready,
        output out_valid,
        output out_sum,
        output out_carry
    );
endinterface

// File: rtl/carry_select_result_sink.sv
// -----------------------------------------------------------------------------
// carry_select_result_sink
//
// Purpose:
//   Receives packed carry-select result words, picks the sum/carry-out pair
//   that matches the running carry (or CIN_INIT on the first beat of a chain),
//   and queues the resolved pairs in a DEPTH-entry FIFO behind valid/ready.
//   Chaining the carry across beats lets a sequence of W-bit slices form one
//   wide addition.
//
// Parameters:
//   W         adder slice width; packed word is 2*W+2 bits
//   DEPTH     FIFO entries, power of two, >= 2
//   CIN_INIT  carry-in used on a beat flagged with first
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       carry_select_result_sink_if.slave (input word + output stream)
//   beat_cnt  [CARRY_SELECT_RESULT_SINK_STATS_EN only] accepted beats, saturating
//   drop_cnt  [CARRY_SELECT_RESULT_SINK_STATS_EN only] guard cycles seen while
//             full, saturating
//
// Optional feature:
//   Define CARRY_SELECT_RESULT_SINK_STATS_EN to add the beat_cnt/drop_cnt
//   statistics outputs. Without it the ports and counters do not exist.
// -----------------------------------------------------------------------------
module carry_select_result_sink #(
    parameter int W        = 4,
    parameter int DEPTH    = 4,
    parameter bit CIN_INIT = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    carry_select_result_sink_if.slave    bus
`ifdef CARRY_SELECT_RESULT_SINK_STATS_EN
    ,
    output logic [15:0]                  beat_cnt,
    output logic [15:0]                  drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Occupancy states; ready and out_valid are decoded straight from these.
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic             carry_q, carry_d;

    // Each entry holds {sum, carry-out}.
    logic [W:0]       mem_q [DEPTH];
    logic [W:0]       headWord;

    logic             readyInt;
    logic             validInt;
    logic             accept;
    logic             pop;
    logic             selCarry;
    logic [W-1:0]     selSum;
    logic             selCout;

    assign readyInt = (state_q != ST_FULL);
    assign validInt = (state_q != ST_EMPTY);
    assign accept   = bus.guard & readyInt;
    assign pop      = validInt & bus.out_ready;

    // Carry select: the effective carry-in is CIN_INIT when the beat opens a
    // new chain and the carry left by the previous accepted beat otherwise.
    // The low slice of the word is the cin=1 sum, the next slice the cin=0 sum.
    always_comb begin
        selCarry = bus.first ? CIN_INIT : carry_q;
        selSum   = selCarry ? bus.value[W-1:0] : bus.value[2*W-1:W];
        selCout  = selCarry ? bus.value[2*W+1] : bus.value[2*W];
    end

    // Next-state logic: pointers advance on their own handshake, the count
    // follows the accept/pop matrix, and the occupancy FSM moves at the
    // boundaries of that count. A full FIFO cannot accept, so leaving FULL
    // only needs a pop.
    always_comb begin
        count_d = count_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        carry_d = carry_q;
        state_d = state_q;

        if (accept) begin
            wrPtr_d = wrPtr_q + 1'b1;
            carry_d = selCout;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (accept && !pop && (count_q == CNT_FULL - CNT_ONE)) begin
                    state_d = ST_FULL;
                end else if (pop && !accept && (count_q == CNT_ONE)) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = ST_PARTIAL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Control registers. Reset empties the FIFO and forgets the running
    // carry, so a chain interrupted by reset restarts from zero carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            carry_q <= carry_d;
        end
    end

    // FIFO storage. No reset is needed: contents are only visible while the
    // FIFO is non-empty, and the head is masked to zero otherwise.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wrPtr_q] <= {selSum, selCout};
        end
    end

    // Outputs come from registered state only, so the input word never
    // reaches the output in the same cycle.
    assign headWord      = mem_q[rdPtr_q];
    assign bus.ready     = readyInt;
    assign bus.out_valid = validInt;
    assign bus.out_sum   = validInt ? headWord[W:1] : '0;
    assign bus.out_carry = validInt & headWord[0];

`ifdef CARRY_SELECT_RESULT_SINK_STATS_EN
    logic [15:0] beatCnt_q;
    logic [15:0] dropCnt_q;

    // Statistics: accepted beats and guard cycles refused because the FIFO
    // was full. Both stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beatCnt_q <= '0;
            dropCnt_q <= '0;
        end else begin
            if (accept && (beatCnt_q != 16'hFFFF)) begin
                beatCnt_q <= beatCnt_q + 16'd1;
            end
            if (bus.guard && !readyInt && (dropCnt_q != 16'hFFFF)) begin
                dropCnt_q <= dropCnt_q + 16'd1;
            end
        end
    end

    assign beat_cnt = beatCnt_q;
    assign drop_cnt = dropCnt_q;
`endif

endmodule

// File: tb/tb_carry_select_result_sink.sv
// -----------------------------------------------------------------------------
// tb_carry_select_result_sink
//
// Directed scenarios followed by a randomized stretch. Operand pairs (a, b)
// are packed into carry-select words, and the expected stream is produced by
// plain integer addition of a + b + carry-in, kept in a queue of
// {sum, carry} results.
// -----------------------------------------------------------------------------
module tb_carry_select_result_sink;

    localparam int W        = 4;
    localparam int DEPTH    = 4;
    localparam bit CIN_INIT = 1'b0;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
    } result_t;

    logic clk;
    logic rst_n;

    carry_select_result_sink_if #(.W(W)) bus ();

`ifdef CARRY_SELECT_RESULT_SINK_STATS_EN
    logic [15:0] beat_cnt;
    logic [15:0] drop_cnt;
`endif

    carry_select_result_sink #(
        .W        (W),
        .DEPTH    (DEPTH),
        .CIN_INIT (CIN_INIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef CARRY_SELECT_RESULT_SINK_STATS_EN
        ,
        .beat_cnt (beat_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    // Reference model state.
    result_t expQ[$];
    bit      modelCarry;
    int      modelBeats;
    int      modelDrops;

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Builds the word a slice adder would produce for operands a and b.
    function automatic logic [2*W+1:0] packValue(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s0;
        logic [W:0] s1;
        s0 = {1'b0, a} + {1'b0, b};
        s1 = s0 + 1'b1;
        return {s1[W], s0[W], s0[W-1:0], s1[W-1:0]};
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compares all outputs against the model's view of the FIFO.
    task automatic checkOutput(input string tag);
        result_t head;
        bit      nonEmpty;
        nonEmpty   = (expQ.size() != 0);
        head.sum   = '0;
        head.carry = 1'b0;
        if (nonEmpty) head = expQ[0];
        checkValue({tag, ".ready"},     32'(bus.ready),     32'(expQ.size() != DEPTH));
        checkValue({tag, ".out_valid"}, 32'(bus.out_valid), 32'(nonEmpty));
        checkValue({tag, ".out_sum"},   32'(bus.out_sum),   32'(head.sum));
        checkValue({tag, ".out_carry"}, 32'(bus.out_carry), 32'(head.carry));
`ifdef CARRY_SELECT_RESULT_SINK_STATS_EN
        checkValue({tag, ".beat_cnt"},  32'(beat_cnt),      32'(modelBeats));
        checkValue({tag, ".drop_cnt"},  32'(drop_cnt),      32'(modelDrops));
`endif
    endtask

    // Model update for one clock edge, using the pre-edge FIFO occupancy.
    task automatic modelStep(input bit g, input bit f, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit oready);
        bit      doAccept;
        bit      doPop;
        int      total;
        result_t r;
        doAccept = g && (expQ.size() < DEPTH);
        doPop    = oready && (expQ.size() != 0);
        if (g && !doAccept) modelDrops++;
        if (doPop) void'(expQ.pop_front());
        if (doAccept) begin
            total   = int'(a) + int'(b) + ((f ? int'(CIN_INIT) : int'(modelCarry)));
            r.sum   = W'(total % (1 << W));
            r.carry = (total >= (1 << W));
            expQ.push_back(r);
            modelCarry = r.carry;
            modelBeats++;
        end
    endtask

    // One cycle: drive at the falling edge, check, then let the edge happen.
    task automatic applyStimulus(input bit g, input bit f, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit oready, input string tag);
        @(negedge clk);
        bus.guard     = g;
        bus.first     = f;
        bus.value     = packValue(a, b);
        bus.out_ready = oready;
        #1;
        checkOutput(tag);
        @(posedge clk);
        modelStep(g, f, a, b, oready);
    endtask

    // Directed check of the head shortly after the edge just taken.
    task automatic expectHead(input string tag, input bit v, input logic [W-1:0] s, input bit c);
        #1;
        checkValue({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        checkValue({tag, ".sum"},   32'(bus.out_sum),   32'(s));
        checkValue({tag, ".carry"}, 32'(bus.out_carry), 32'(c));
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic doReset(input string tag);
        @(negedge clk);
        bus.guard     = 1'b0;
        bus.first     = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkValue({tag, ".rst.out_valid"}, 32'(bus.out_valid), 32'd0);
        checkValue({tag, ".rst.ready"},     32'(bus.ready),     32'd1);
        checkValue({tag, ".rst.out_sum"},   32'(bus.out_sum),   32'd0);
        checkValue({tag, ".rst.out_carry"}, 32'(bus.out_carry), 32'd0);
        expQ.delete();
        modelCarry = 1'b0;
        modelBeats = 0;
        modelDrops = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        modelCarry    = 1'b0;
        modelBeats    = 0;
        modelDrops    = 0;
        rst_n         = 1'b0;
        bus.guard     = 1'b0;
        bus.first     = 1'b0;
        bus.value     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        #1;
        checkValue("reset.ready",     32'(bus.ready),     32'd1);
        checkValue("reset.out_valid", 32'(bus.out_valid), 32'd0);
        checkValue("reset.out_sum",   32'(bus.out_sum),   32'd0);
        checkValue("reset.out_carry", 32'(bus.out_carry), 32'd0);

        // Single beat 3+5.
        applyStimulus(1'b1, 1'b1, 4'd3, 4'd5, 1'b1, "single");
        expectHead("single", 1'b1, 4'd8, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "drain1");

        // Carry chain F+1 then 2+3 with carry in.
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd1, 1'b0, "chain1");
        expectHead("chain1", 1'b1, 4'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'd2, 4'd3, 1'b1, "chain2");
        expectHead("chain2", 1'b1, 4'd6, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "drain2");

        // Chain restart: first on the second beat discards the carry.
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd1, 1'b1, "restart1");
        expectHead("restart1", 1'b1, 4'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 4'd2, 4'd3, 1'b1, "restart2");
        expectHead("restart2", 1'b1, 4'd5, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "drain3");

        // Backpressure: fill, drop one, then drain in order.
        doReset("bp");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, (i == 0), 4'(i + 7), 4'(i + 9), 1'b0, "bpFill");
        end
        #1;
        checkValue("bpFull.ready", 32'(bus.ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'd7, 4'd7, 1'b0, "bpDrop");
`ifdef CARRY_SELECT_RESULT_SINK_STATS_EN
        #1;
        checkValue("bpDrop.drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "bpPop1");
        #1;
        checkValue("bpPop1.ready", 32'(bus.ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "bpDrain");
        end

        // Simultaneous push and pop at count 2 across pointer wrap.
        applyStimulus(1'b1, 1'b1, 4'd1, 4'd2, 1'b0, "simFill");
        applyStimulus(1'b1, 1'b0, 4'd9, 4'd9, 1'b0, "simFill");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, "simPushPop");
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "simDrain");
        end

        // Reset mid-stream with three entries and running carry 1.
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd1, 1'b0, "mid1");
        applyStimulus(1'b1, 1'b0, 4'hF, 4'd0, 1'b0, "mid2");
        applyStimulus(1'b1, 1'b0, 4'hF, 4'd0, 1'b0, "mid3");
        doReset("mid");
        applyStimulus(1'b1, 1'b0, 4'd2, 4'd3, 1'b1, "postReset");
        expectHead("postReset", 1'b1, 4'd5, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "drain4");

        // Randomized traffic against the arithmetic model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0), "rand");
        end
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "finalDrain");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/carry_select_result_sink.md
Name: carry_select_result_sink

Overview:
- Consumer at the receiving end of the guarded `guard`/`value` result interface driven by the generated carry-select adder blocks.
- Each accepted packed result word carries two precomputed sums and two carry-outs, one pair per possible carry-in.
- The block resolves each word against a running carry, which allows multi-beat wide additions, and buffers the resolved sum/carry pairs in a small FIFO behind a valid/ready output.

Parameters:
- W, 4: adder slice width. Packed value width is 2*W+2.
- DEPTH, 4: FIFO entries, power of two, >= 2.
- CIN_INIT, 0: carry-in applied to the first beat of a chain.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- guard  in  1  producer result valid.
- value  in  2W+2  packed result word:
  - [2W+1] = carry-out for cin=1
  - [2W] = carry-out for cin=0
  - [2W-1:W] = sum for cin=0
  - [W-1:0] = sum for cin=1
- first  in  1  qualifies `guard`; the beat starts a new chain.
- ready  out  1  sink can accept this cycle.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head.
- out_sum  out  W  resolved sum at the head.
- out_carry  out  1  resolved carry-out at the head.

Behaviour:
- Reset (async, rst_n=0) sets:
  - FIFO count, read pointer and write pointer to 0.
  - carry_q to 0.
  - out_valid = 0, out_sum = 0, out_carry = 0, ready = 1.
  - Reset mid-chain discards every buffered entry and the running carry.
- ready = (count != DEPTH). It is a registered-state function only and never depends on `guard`.
- accept = guard & ready. When ready=0 the word is dropped; holding the word is the producer's job.
- Carry select, combinational:
  - c = first ? CIN_INIT : carry_q.
  - sum = c ? value[W-1:0] : value[2W-1:W].
  - cout = c ? value[2W+1] : value[2W].
- On accept:
  - Write {sum, cout} at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
  - carry_q <= cout.
- Without accept, carry_q holds.
- pop = out_valid & out_ready. rd_ptr increments and wraps modulo DEPTH.
- Latency: an accepted word appears at out_valid/out_sum/out_carry on the next rising edge when the FIFO was empty. There is no combinational input-to-output path.
- out_valid = (count != 0). When count == 0, out_sum and out_carry are forced to 0.
- Simultaneous accept and pop: count is unchanged and both pointers advance. This is legal at any count from 1 to DEPTH-1.
- Full: accept is impossible; a pop in the same cycle frees an entry, and ready rises on the next cycle.
- Empty with out_ready=1: no pop occurs and state is unchanged.
- `first` is ignored when guard=0.
- State machine over count, with ready/out_valid decoded from it:
  - EMPTY (count=0)
  - PARTIAL (0 < count < DEPTH)
  - FULL (count=DEPTH)
  - Transitions use the accept/pop matrix above.

Optional Feature:
- Macro: CARRY_SELECT_RESULT_SINK_STATS_EN.
- When defined, the block adds two outputs:
  - beat_cnt[15:0]: accepted beats, saturates at 0xFFFF.
  - drop_cnt[15:0]: cycles with guard=1 & ready=0, saturates at 0xFFFF.
  - Both reset to 0.
- When undefined, neither port nor its logic exists, and behaviour is otherwise identical.

Test Plan:
- Single beat. After reset, ready=1 and out_valid=0. Drive guard=1, first=1, value=0x089 (3+5) -> next cycle out_valid=1, out_sum=8, out_carry=0.
- Carry chain:
  - Beat 1: first=1, value=0x301 (F+1) -> out_sum=0, out_carry=1.
  - Beat 2: first=0, value=0x056 (2+3) -> out_sum=6, out_carry=0, because carry_q=1 selects the cin=1 sum.
- Chain restart: repeat the chain, but drive first=1 on the 0x056 beat -> out_sum=5 with CIN_INIT=0.
- Backpressure with out_ready=0:
  - Push 4 beats -> ready=0 after the 4th.
  - A 5th guard beat is dropped (drop_cnt=1 with STATS_EN).
  - Release out_ready -> entries emerge in order; ready rises one cycle after the first pop.
- Simultaneous push and pop at count=2 -> count stays 2 and output order is preserved across pointer wrap after 8+ beats.
- Assert rst_n=0 mid-stream with 3 entries buffered and carry_q=1 -> out_valid=0 and ready=1 immediately. A following first=0 beat with value=0x056 yields out_sum=5.
